// File: rtl/forth_stack_cached_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | forth_pkg : shared constants and types for the cached Forth stack   |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package forth_pkg;

   localparam int WIDTH_DEFAULT = 16;

   // Offset is a 2-bit two's-complement pointer move
   localparam logic [1:0] OFFSET_NOP  = 2'b00;
   localparam logic [1:0] OFFSET_PUSH = 2'b01;
   localparam logic [1:0] OFFSET_POP2 = 2'b10;
   localparam logic [1:0] OFFSET_POP  = 2'b11;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'b00,
      ERR_OVERFLOW  = 2'b01,
      ERR_UNDERFLOW = 2'b10,
      ERR_EMPTY_WR  = 2'b11
   } err_code_e;

   function automatic int ram_aw(input int depth);
      return (depth - 2 > 1) ? $clog2(depth - 2) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/forth_stack_cached_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | forth_stack_cached_if : operation/result bundle of the Forth stack  |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
interface forth_stack_cached_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int PTR_W = $clog2(DEPTH + 1)
);
   logic             TWrite;
   logic             NWrite;
   logic [WIDTH-1:0] WData;
   logic [1:0]       Offset;
   logic [WIDTH-1:0] T;
   logic [WIDTH-1:0] N;
   logic [PTR_W-1:0] Depth;
   logic             Err;
   logic [1:0]       ErrCode;
   logic [PTR_W-1:0] HighWater;

   modport master (
      output TWrite, NWrite, WData, Offset,
      input  T, N, Depth, Err, ErrCode, HighWater
   );

   modport slave (
      input  TWrite, NWrite, WData, Offset,
      output T, N, Depth, Err, ErrCode, HighWater
   );
endinterface
`default_nettype wire

// File: rtl/forth_stack_cached_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | forth_stack_ram : spill store, 1 sync write port, 2 async reads     |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module forth_stack_ram #(
   parameter int WIDTH   = 16,
   parameter int ENTRIES = 254,
   parameter int AW      = 8
) (
   input  wire logic             Clk,
   input  wire logic             we_i,
   input  wire logic [AW-1:0]    waddr_i,
   input  wire logic [WIDTH-1:0] wdata_i,
   input  wire logic [AW-1:0]    raddr_a_i,
   input  wire logic [AW-1:0]    raddr_b_i,
   output      logic [WIDTH-1:0] rdata_a_o,
   output      logic [WIDTH-1:0] rdata_b_o
);
   logic [WIDTH-1:0] mem_q [0:ENTRIES-1];

   always_ff @(posedge Clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];
endmodule
`default_nettype wire

// File: rtl/forth_stack_cached.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | forth_stack_cached : Forth stack, T/N in flops, deeper cells in RAM |
// | Optional HighWater tracking: FORTH_STACK_HWM_EN     Revision : 1.0  |
// +--------------------------------------------------------------------+
module forth_stack_cached
   import forth_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = 256,
   parameter int PTR_W = $clog2(DEPTH + 1)
) (
   input wire logic Clk,
   input wire logic Rst,
   forth_stack_cached_if.slave bus
);
   localparam int RAM_AW = ram_aw(DEPTH);
   localparam logic signed [PTR_W+1:0] DEPTH_S = (PTR_W+2)'(DEPTH);

   logic [PTR_W-1:0]        depth_q, depth_d;
   logic [WIDTH-1:0]        t_q, t_d, n_q, n_d;
   logic                    err_q, err_d;
   err_code_e               code_q, code_d;
   logic signed [PTR_W+1:0] nd;
   logic [PTR_W-1:0]        nd_u;
   logic                    ram_we;
   logic [RAM_AW-1:0]       ram_waddr, ram_raddr_a, ram_raddr_b;
   logic [WIDTH-1:0]        ram_rdata_a, ram_rdata_b;

   assign nd   = $signed({2'b00, depth_q}) + $signed({{PTR_W{bus.Offset[1]}}, bus.Offset});
   assign nd_u = nd[PTR_W-1:0];

   // d-3 and d-4 address the two cells directly beneath N
   assign ram_raddr_a = RAM_AW'(depth_q - PTR_W'(3));
   assign ram_raddr_b = RAM_AW'(depth_q - PTR_W'(4));
   assign ram_waddr   = RAM_AW'(depth_q - PTR_W'(2));

   forth_stack_ram #(
      .WIDTH   (WIDTH),
      .ENTRIES (DEPTH - 2),
      .AW      (RAM_AW)
   ) u_ram (
      .Clk       (Clk),
      .we_i      (ram_we),
      .waddr_i   (ram_waddr),
      .wdata_i   (n_q),
      .raddr_a_i (ram_raddr_a),
      .raddr_b_i (ram_raddr_b),
      .rdata_a_o (ram_rdata_a),
      .rdata_b_o (ram_rdata_b)
   );

   always_comb begin
      depth_d = depth_q;
      t_d     = t_q;
      n_d     = n_q;
      err_d   = err_q;
      code_d  = code_q;
      ram_we  = 1'b0;
      if (nd > DEPTH_S) begin
         err_d  = 1'b1;
         code_d = ERR_OVERFLOW;
      end else if (nd[PTR_W+1]) begin
         err_d  = 1'b1;
         code_d = ERR_UNDERFLOW;
      end else begin
         depth_d = nd_u;
         case (bus.Offset)
            OFFSET_PUSH: begin
               ram_we = (depth_q >= PTR_W'(2));
               n_d    = t_q;
               t_d    = '0;
            end
            OFFSET_POP: begin
               t_d = n_q;
               n_d = (nd_u >= PTR_W'(2)) ? ram_rdata_a : '0;
            end
            OFFSET_POP2: begin
               t_d = (nd_u >= PTR_W'(1)) ? ram_rdata_a : '0;
               n_d = (nd_u >= PTR_W'(2)) ? ram_rdata_b : '0;
            end
            default: ;
         endcase
         // Writes to a slot absent after the move are dropped; the move itself stands
         if (bus.TWrite) begin
            if (nd_u == '0) begin
               err_d  = 1'b1;
               code_d = ERR_EMPTY_WR;
            end else begin
               t_d = bus.WData;
            end
         end
         if (bus.NWrite) begin
            if (nd_u <= PTR_W'(1)) begin
               err_d  = 1'b1;
               code_d = ERR_EMPTY_WR;
            end else begin
               n_d = bus.WData;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         depth_q <= '0;
         t_q     <= '0;
         n_q     <= '0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         depth_q <= depth_d;
         t_q     <= t_d;
         n_q     <= n_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign bus.T       = t_q;
   assign bus.N       = n_q;
   assign bus.Depth   = depth_q;
   assign bus.Err     = err_q;
   assign bus.ErrCode = code_q;

`ifdef FORTH_STACK_HWM_EN
   logic [PTR_W-1:0] hwm_q, hwm_d;

   assign hwm_d = (depth_d > hwm_q) ? depth_d : hwm_q;

   always_ff @(posedge Clk) begin
      if (Rst) hwm_q <= '0;
      else     hwm_q <= hwm_d;
   end

   assign bus.HighWater = hwm_q;
`else
   assign bus.HighWater = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_forth_stack_cached.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_forth_stack_cached : directed + random check against a queue model|
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_forth_stack_cached;
   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int PTR_W = $clog2(DEPTH + 1);

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [WIDTH-1:0] mdl [$];
   logic             m_err;
   logic [1:0]       m_code;
   int               m_hwm;

   forth_stack_cached_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   forth_stack_cached #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      logic [WIDTH-1:0] et, en;
      int eh;
      sz = mdl.size();
      et = (sz > 0) ? mdl[sz-1] : '0;
      en = (sz > 1) ? mdl[sz-2] : '0;
`ifdef FORTH_STACK_HWM_EN
      eh = m_hwm;
`else
      eh = 0;
`endif
      chk({tag, ".T"},       32'(bus.T),         32'(et));
      chk({tag, ".N"},       32'(bus.N),         32'(en));
      chk({tag, ".Depth"},   32'(bus.Depth),     32'(sz));
      chk({tag, ".Err"},     32'(bus.Err),       32'(m_err));
      chk({tag, ".ErrCode"}, 32'(bus.ErrCode),   32'(m_code));
      chk({tag, ".HWM"},     32'(bus.HighWater), 32'(eh));
   endtask

   // Stack semantics: push adds a zero cell, pops remove cells, writes patch top cells
   task automatic model_apply(input logic [1:0] off, input logic tw, input logic nw,
                              input logic [WIDTH-1:0] wd);
      int mv, nd;
      case (off)
         2'b01:   mv = 1;
         2'b00:   mv = 0;
         2'b11:   mv = -1;
         default: mv = -2;
      endcase
      nd = mdl.size() + mv;
      if (nd > DEPTH) begin
         m_err = 1'b1; m_code = 2'b01;
      end else if (nd < 0) begin
         m_err = 1'b1; m_code = 2'b10;
      end else begin
         if (mv == 1) mdl.push_back('0);
         for (int k = 0; k < -mv; k++) void'(mdl.pop_back());
         if (tw) begin
            if (nd == 0) begin m_err = 1'b1; m_code = 2'b11; end
            else mdl[nd-1] = wd;
         end
         if (nw) begin
            if (nd <= 1) begin m_err = 1'b1; m_code = 2'b11; end
            else mdl[nd-2] = wd;
         end
         if (nd > m_hwm) m_hwm = nd;
      end
   endtask

   task automatic idle_inputs();
      bus.Offset = 2'b00; bus.TWrite = 1'b0; bus.NWrite = 1'b0; bus.WData = '0;
   endtask

   task automatic model_reset();
      mdl.delete(); m_err = 1'b0; m_code = 2'b00; m_hwm = 0;
   endtask

   task automatic step(input logic [1:0] off, input logic tw, input logic nw,
                       input logic [WIDTH-1:0] wd, input string tag);
      bus.Offset = off; bus.TWrite = tw; bus.NWrite = nw; bus.WData = wd;
      @(posedge Clk); #1;
      model_apply(off, tw, nw, wd);
      check_all(tag);
      idle_inputs();
   endtask

   task automatic do_reset(input string tag);
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      model_reset();
      check_all(tag);
   endtask

   initial begin
      logic [1:0] off;
      int r;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      do_reset("reset");

      step(2'b01, 1'b1, 1'b0, 16'h1111, "push1");
      step(2'b01, 1'b1, 1'b0, 16'h2222, "push2");
      step(2'b01, 1'b1, 1'b0, 16'h3333, "push3");
      step(2'b11, 1'b1, 1'b0, 16'h5555, "binop");
      step(2'b10, 1'b0, 1'b0, 16'h0000, "pop2_to_empty");
      step(2'b11, 1'b0, 1'b0, 16'h0000, "underflow");
      step(2'b00, 1'b0, 1'b0, 16'h0000, "nop_after_err");

      do_reset("reset2");
      for (int i = 0; i < DEPTH; i++)
         step(2'b01, 1'b1, 1'b0, WIDTH'(16'hA000 + i), "fill");
      step(2'b01, 1'b1, 1'b1, 16'hDEAD, "overflow");
      for (int i = 0; i < DEPTH; i++)
         step(2'b11, 1'b0, 1'b0, 16'h0000, "drain");

      do_reset("reset3");
      step(2'b01, 1'b1, 1'b0, 16'h0001, "wpush1");
      step(2'b01, 1'b1, 1'b0, 16'h0002, "wpush2");
      step(2'b00, 1'b1, 1'b1, 16'hABCD, "write_both");
      step(2'b11, 1'b0, 1'b0, 16'h0000, "pop_to_one");
      step(2'b00, 1'b0, 1'b1, 16'h1234, "nwrite_empty");
      step(2'b11, 1'b1, 1'b0, 16'h4321, "twrite_empty");

      step(2'b01, 1'b1, 1'b0, 16'h7777, "pre_rst_push");
      bus.Offset = 2'b01; bus.TWrite = 1'b1; bus.WData = 16'h9999;
      do_reset("rst_mid_push");
      idle_inputs();

      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 299) begin
            do_reset("rand_reset");
         end else begin
            r = $urandom_range(0, 9);
            if (r < 4)      off = 2'b01;
            else if (r < 6) off = 2'b00;
            else if (r < 8) off = 2'b11;
            else if (r < 9) off = 2'b10;
            else            off = 2'($urandom_range(0, 3));
            step(off, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 WIDTH'($urandom_range(0, 16'hFFFF)), "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
